// File: rtl/aes_link_mux.sv
// N-channel front end for the shared AES core: per-channel block FIFOs, round-robin issue,
// channel tagging of in-flight blocks, and the per-key block budget with drain/rekey handshake.
//
// state    | meaning
// WAIT_KEY | no long key established; nothing issued
// RUN      | arbitrating channels and issuing blocks to the core
// DRAIN    | key budget spent; waiting for in-flight results to return
// REKEY    | key_ch pulsed; waiting for the new key before resuming
module aes_link_mux #(
    parameter int  N_CH     = 4,
    parameter int  DATA_W   = 128,
    parameter int  DEPTH    = 4,
    parameter int  MAX_INFL = 8,
    parameter int  KEY_LIFE = 1024,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          ch_in_stb,
    input  logic [N_CH*DATA_W-1:0]   ch_in_data,
    output logic [N_CH-1:0]          ch_full,
    input  logic                     core_ready,
    input  logic                     core_key_valid,
    output logic                     core_in_stb,
    output logic [DATA_W-1:0]        core_in_data,
    input  logic                     core_out_valid,
    input  logic [DATA_W-1:0]        core_out_data,
    output logic                     key_change_rq,
    output logic                     key_ch,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [CH_W-1:0]          out_ch,
    output logic                     err_orphan
);

    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int TW  = (MAX_INFL > 1) ? $clog2(MAX_INFL) : 1;
    localparam int TCW = $clog2(MAX_INFL + 1);
    localparam int BCW = $clog2(KEY_LIFE + 1);

    typedef enum logic [1:0] {
        S_WAIT_KEY,
        S_RUN,
        S_DRAIN,
        S_REKEY
    } state_t;

    state_t state, state_nx;
    logic   enter_rekey;

    logic [DATA_W-1:0] fifo_mem [N_CH][DEPTH];
    logic [AW-1:0]     fifo_wp  [N_CH];
    logic [AW-1:0]     fifo_rp  [N_CH];
    logic [FCW-1:0]    fifo_cnt [N_CH];
    logic [N_CH-1:0]   fifo_wr;
    logic [N_CH-1:0]   fifo_rd;
    logic [N_CH-1:0]   ch_nempty;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   win;
    logic              found;
    logic              issue;

    logic [CH_W-1:0]   tag_mem [MAX_INFL];
    logic [TW-1:0]     tag_wp;
    logic [TW-1:0]     tag_rp;
    logic [TCW-1:0]    tag_cnt;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_pop;

    logic [BCW-1:0]    blk_cnt;
    logic [1:0]        rk_tmr;
    logic              seen_low;

    function automatic logic [AW-1:0] fifo_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
        return (p == TW'(MAX_INFL - 1)) ? '0 : p + 1'b1;
    endfunction

    // ---------------- per-channel input FIFOs ----------------
    always_comb begin
        ch_full   = '0;
        ch_nempty = '0;
        fifo_wr   = '0;
        for (int c = 0; c < N_CH; c++) begin
            ch_full[c]   = (fifo_cnt[c] == FCW'(DEPTH));
            ch_nempty[c] = (fifo_cnt[c] != '0);
            fifo_wr[c]   = ch_in_stb[c] && !ch_full[c];
        end
    end

    always_comb begin
        fifo_rd = '0;
        for (int c = 0; c < N_CH; c++) begin
            fifo_rd[c] = issue && (win == CH_W'(c));
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (fifo_wr[c]) begin
                fifo_mem[c][fifo_wp[c]] <= ch_in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < N_CH; c++) begin
                fifo_wp[c]  <= '0;
                fifo_rp[c]  <= '0;
                fifo_cnt[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (fifo_wr[c]) fifo_wp[c] <= fifo_inc(fifo_wp[c]);
                if (fifo_rd[c]) fifo_rp[c] <= fifo_inc(fifo_rp[c]);
                fifo_cnt[c] <= fifo_cnt[c] + FCW'(fifo_wr[c]) - FCW'(fifo_rd[c]);
            end
        end
    end

    // ---------------- round-robin arbiter ----------------
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = rr_ptr;
        for (int i = 0; i < N_CH; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= N_CH) idx = idx - N_CH;
            if (!found && ch_nempty[idx]) begin
                found = 1'b1;
                win   = CH_W'(idx);
            end
        end
    end

    // A dropping key blocks issue in the same cycle the FSM leaves RUN.
    assign issue = (state == S_RUN) && core_key_valid && core_ready && !tag_full && found;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            core_in_stb  <= 1'b0;
            core_in_data <= '0;
            rr_ptr       <= '0;
        end else begin
            core_in_stb <= issue;
            if (issue) begin
                core_in_data <= fifo_mem[win][fifo_rp[win]];
                rr_ptr       <= (win == CH_W'(N_CH - 1)) ? '0 : win + 1'b1;
            end
        end
    end

    // ---------------- in-flight tag FIFO ----------------
    assign tag_full  = (tag_cnt == TCW'(MAX_INFL));
    assign tag_empty = (tag_cnt == '0);
    assign tag_pop   = core_out_valid && !tag_empty;

    always_ff @(posedge clk) begin
        if (issue) tag_mem[tag_wp] <= win;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_wp  <= '0;
            tag_rp  <= '0;
            tag_cnt <= '0;
        end else begin
            if (issue)   tag_wp <= tag_inc(tag_wp);
            if (tag_pop) tag_rp <= tag_inc(tag_rp);
            tag_cnt <= tag_cnt + TCW'(issue) - TCW'(tag_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_ch     <= '0;
            err_orphan <= 1'b0;
        end else begin
            out_valid <= tag_pop;
            if (tag_pop) begin
                out_data <= core_out_data;
                out_ch   <= tag_mem[tag_rp];
            end
            if (core_out_valid && tag_empty) err_orphan <= 1'b1;
        end
    end

    // ---------------- key sequencing FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_WAIT_KEY;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        enter_rekey = 1'b0;
        case (state)
            S_WAIT_KEY: begin
                if (core_key_valid) state_nx = S_RUN;
            end
            S_RUN: begin
                if (!core_key_valid) begin
                    state_nx = S_WAIT_KEY;
                end else if (issue && (blk_cnt == BCW'(KEY_LIFE - 1))) begin
                    state_nx = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // last result returning this cycle also counts as drained
                if (tag_empty || ((tag_cnt == TCW'(1)) && core_out_valid)) begin
                    state_nx    = S_REKEY;
                    enter_rekey = 1'b1;
                end
            end
            S_REKEY: begin
                if (core_key_valid && (seen_low || (rk_tmr == 2'd0))) state_nx = S_RUN;
            end
            default: state_nx = S_WAIT_KEY;
        endcase
    end

    assign key_change_rq = (state == S_DRAIN) || (state == S_REKEY);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blk_cnt  <= '0;
            rk_tmr   <= '0;
            seen_low <= 1'b0;
            key_ch   <= 1'b0;
        end else begin
            key_ch <= enter_rekey;
            if (enter_rekey) begin
                blk_cnt  <= '0;
                rk_tmr   <= 2'd2;
                seen_low <= 1'b0;
            end else begin
                if (issue) blk_cnt <= blk_cnt + 1'b1;
                if (state == S_REKEY) begin
                    if (rk_tmr != 2'd0)  rk_tmr   <= rk_tmr - 1'b1;
                    if (!core_key_valid) seen_low <= 1'b1;
                end
            end
        end
    end

endmodule
